operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/of_pkg.sv | 15 +
 rtl/of_regfile.sv | 47 ++++
 rtl/operand_fetch.sv | 72 +++++++
 tb/tb_operand_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// Shared types and default sizing for the operand fetch stage.
// Holds the ALU op encoding and the default datapath width and register count.
package of_pkg;

    localparam int OF_N    = 32;
    localparam int OF_REGS = 16;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_AND    = 2'b01,
        ALU_PASS_B = 2'b10,
        ALU_RSVD   = 2'b11
    } alu_op_t;

endpackage

// File: rtl/of_regfile.sv
// Register file: two async read ports, one sync write port, R0 reads as zero.
// Latency: reads combinational, write visible next cycle (same cycle with OF_WB_FORWARD_EN).
// Backpressure: none; writes are always accepted.
module of_regfile
    import of_pkg::*;
#(
    parameter int N    = OF_N,
    parameter int REGS = OF_REGS,
    localparam int IW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [IW-1:0] raddr1,
    input  logic [IW-1:0] raddr2,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2
);

    logic [N-1:0] mem [REGS];
    logic         wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
`ifdef OF_WB_FORWARD_EN
        // Bypass the write port so a same-cycle write-back is seen by the reader.
        if (wr_live && (waddr == raddr1)) rdata1 = wdata;
        if (wr_live && (waddr == raddr2)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads rs1/rs2 (or imm) into a one-entry register toward the ALU. Option macro: OF_WB_FORWARD_EN.
// Latency: one cycle from transfer in to out_valid; full throughput.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module operand_fetch
    import of_pkg::*;
#(
    parameter int N    = OF_N,
    parameter int REGS = OF_REGS,
    localparam int IW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  alu_op_t       in_op,
    input  logic [IW-1:0] in_rs1,
    input  logic [IW-1:0] in_rs2,
    input  logic [IW-1:0] in_rd,
    input  logic [N-1:0]  in_imm,
    input  logic          in_use_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output alu_op_t       out_op,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic [IW-1:0] out_rd,
    input  logic          wb_en,
    input  logic [IW-1:0] wb_rd,
    input  logic [N-1:0]  wb_data
);

    logic [N-1:0] rs1_val;
    logic [N-1:0] rs2_val;
    logic         xfer_in;

    assign in_ready = !out_valid || out_ready;
    assign xfer_in  = in_valid && in_ready;

    of_regfile #(
        .N    (N),
        .REGS (REGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (in_rs1),
        .raddr2 (in_rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op    <= ALU_ADD;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_a     <= rs1_val;
            out_b     <= in_use_imm ? in_imm : rs2_val;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: vector table plus hand sequences for forwarding, stall and reset,
// with a queue of expected outputs popped on every ALU-side transfer.
module tb_operand_fetch;
    import of_pkg::*;

    localparam int N    = 32;
    localparam int REGS = 16;
    localparam int IW   = 4;

`ifdef OF_WB_FORWARD_EN
    localparam logic [31:0] FWD_VAL = 32'h0000_1234;
`else
    localparam logic [31:0] FWD_VAL = 32'h0000_0000;
`endif

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
    } exp_t;

    typedef struct {
        logic [3:0]  wb_rd;
        logic [31:0] wb_data;
        alu_op_t     op;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    alu_op_t       in_op;
    logic [IW-1:0] in_rs1;
    logic [IW-1:0] in_rs2;
    logic [IW-1:0] in_rd;
    logic [N-1:0]  in_imm;
    logic          in_use_imm;
    logic          out_valid;
    logic          out_ready;
    alu_op_t       out_op;
    logic [N-1:0]  out_a;
    logic [N-1:0]  out_b;
    logic [IW-1:0] out_rd;
    logic          wb_en;
    logic [IW-1:0] wb_rd;
    logic [N-1:0]  wb_data;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   n0;
    exp_t q[$];
    exp_t e;
    vec_t vecs[6];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    logic [3:0]  prev_rd;

    operand_fetch #(
        .N    (N),
        .REGS (REGS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_op      = ALU_ADD;
        in_rs1     = '0;
        in_rs2     = '0;
        in_rd      = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        wb_en      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        out_ready  = 1'b1;
    endtask

    task automatic issue(input alu_op_t op, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic use_imm, input logic [31:0] imm,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_use_imm = use_imm;
        in_imm     = imm;
        q.push_back('{op, exp_a, exp_b, rd});
    endtask

    // Output side: pop one expectation per transfer out, and require stable outputs across a stall.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_a", out_a, prev_a);
                check("hold_b", out_b, prev_b);
                check("hold_rd", 32'(out_rd), 32'(prev_rd));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got out_a=0x%08h, required no transfer", out_a);
                end else begin
                    e = q.pop_front();
                    check("out_op", 32'(out_op), 32'(e.op));
                    check("out_a", out_a, e.a);
                    check("out_b", out_b, e.b);
                    check("out_rd", 32'(out_rd), 32'(e.rd));
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_a     = out_a;
            prev_b     = out_b;
            prev_rd    = out_rd;
        end
    end

    initial begin
        vecs[0] = '{4'd3,  32'h0000_00AA, ALU_ADD,    4'd3,  4'd0,  4'd1,  1'b0, 32'h0,         32'h0000_00AA, 32'h0000_0000};
        vecs[1] = '{4'd0,  32'hFFFF_FFFF, ALU_AND,    4'd0,  4'd3,  4'd2,  1'b0, 32'h0,         32'h0000_0000, 32'h0000_00AA};
        vecs[2] = '{4'd7,  32'h0000_0055, ALU_PASS_B, 4'd7,  4'd7,  4'd4,  1'b1, 32'hDEAD_BEEF, 32'h0000_0055, 32'hDEAD_BEEF};
        vecs[3] = '{4'd15, 32'h8000_0001, ALU_ADD,    4'd15, 4'd7,  4'd15, 1'b0, 32'h0,         32'h8000_0001, 32'h0000_0055};
        vecs[4] = '{4'd3,  32'h1234_5678, ALU_RSVD,   4'd3,  4'd15, 4'd0,  1'b0, 32'h0,         32'h1234_5678, 32'h8000_0001};
        vecs[5] = '{4'd1,  32'hFFFF_FFFF, ALU_ADD,    4'd1,  4'd0,  4'd9,  1'b1, 32'h0,         32'hFFFF_FFFF, 32'h0000_0000};

        idle();
        rst = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Write-back one cycle, issue the next, drain the third.
        for (int i = 0; i < 6; i++) begin
            wb_en   = 1'b1;
            wb_rd   = vecs[i].wb_rd;
            wb_data = vecs[i].wb_data;
            step();
            wb_en = 1'b0;
            issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].use_imm, vecs[i].imm, vecs[i].exp_a, vecs[i].exp_b);
            check("pre_issue_valid", 32'(out_valid), 32'd0);
            step();
            check("latency_valid", 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            step();
        end

        // Write-back and read of the same register in one cycle.
        wb_en   = 1'b1;
        wb_rd   = 4'd5;
        wb_data = 32'h0000_1234;
        issue(ALU_ADD, 4'd5, 4'd5, 4'd5, 1'b0, 32'h0, FWD_VAL, FWD_VAL);
        step();
        wb_en = 1'b0;
        issue(ALU_ADD, 4'd5, 4'd0, 4'd6, 1'b0, 32'h0, 32'h0000_1234, 32'h0);
        step();
        in_valid = 1'b0;
        step();

        // Stall for four cycles with a second instruction waiting, then stream.
        out_ready = 1'b0;
        issue(ALU_AND, 4'd3, 4'd7, 4'd6, 1'b0, 32'h0, 32'h1234_5678, 32'h0000_0055);
        step();
        issue(ALU_ADD, 4'd15, 4'd1, 4'd7, 1'b0, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_a", out_a, 32'h1234_5678);
            step();
        end
        out_ready = 1'b1;
        n0 = n_out;
        step();
        issue(ALU_ADD, 4'd0, 4'd3, 4'd8, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
        step();
        issue(ALU_PASS_B, 4'd1, 4'd2, 4'd9, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hCAFE_F00D);
        step();
        in_valid = 1'b0;
        step();
        check("b2b_out_count", 32'(n_out - n0), 32'd4);

        // Reset while an instruction is staged and a write-back is in flight.
        out_ready = 1'b0;
        issue(ALU_ADD, 4'd3, 4'd0, 4'd2, 1'b0, 32'h0, 32'h1234_5678, 32'h0);
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst     = 1'b1;
        wb_en   = 1'b1;
        wb_rd   = 4'd9;
        wb_data = 32'h0000_0077;
        step();
        rst       = 1'b0;
        wb_en     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_a", out_a, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < REGS; i++) begin
            issue(ALU_ADD, 4'(i), 4'(i), 4'(i), 1'b0, 32'h0, 32'h0, 32'h0);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
